// File: rtl/uart_rx_frame_decoder_pkg.sv
// uart_rx_frame_decoder_pkg: frame tags, feedback bit map, FSM encoding and defaults for the rx decoder
package uart_rx_frame_decoder_pkg;
  localparam logic [1:0] TAG_FEEDBACK = 2'b01;
  localparam logic [1:0] TAG_SCRIPT = 2'b10;
  localparam int SCRIPT_START_BIT = 2;
  localparam int FB_FRONT_BIT = 2;
  localparam int FB_HAND_BIT = 3;
  localparam int FB_PROCESSING_BIT = 4;
  localparam int FB_MACHINE_BIT = 5;
  localparam int DEFAULT_TIMEOUT_CYCLES = 153600;
  typedef enum logic [2:0] {IDLE, LEN, DATA_LO, DATA_HI, CHK, DONE, ERR} state_t;
  function automatic logic is_load_start(input logic [7:0] b);
    return b[1:0] == TAG_SCRIPT && b[SCRIPT_START_BIT];
  endfunction
endpackage

// File: rtl/uart_rx_frame_decoder_rx_byte_strobe.sv
// rx_byte_strobe: one-cycle accept strobe per rising edge of data_valid, byte aligned to the strobe
module rx_byte_strobe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_receive,
  input  logic       data_valid,
  output logic       stb,
  output logic [7:0] data
);
  logic valid_q;
  // Remember last cycle's qualifier so a held-high valid yields a single strobe
  always_ff @(posedge clk) valid_q <= rst_n ? data_valid : 1'b0;
  assign stb = data_valid & ~valid_q;
  assign data = data_receive;
endmodule

// File: rtl/uart_rx_frame_decoder.sv
// uart_rx_frame_decoder: splits UART rx bytes into feedback status flags and script-memory loads
// Optional: define SCRIPT_CHECKSUM_EN to require a trailing XOR checksum byte after each non-empty load
module uart_rx_frame_decoder
  import uart_rx_frame_decoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              uart_clk,
  input  logic              rst_n,
  input  logic [7:0]        data_receive,
  input  logic              data_valid,
  output logic              sig_front,
  output logic              sig_hand,
  output logic              sig_processing,
  output logic              sig_machine,
  output logic              script_mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [7:0]        script_num,
  output logic              load_done,
  output logic              load_err
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MAX_N = 2 ** ADDR_W;
  state_t state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, idx_q, idx_d, n_clip;
  logic [7:0] lo_q, lo_d, script_num_q, script_num_d, rx_byte;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0] sig_q, sig_d;
  logic script_mode_q, script_mode_d, wr_en_q, wr_en_d;
  logic load_done_q, load_done_d, load_err_q, load_err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic stb, active, expired, go_done, go_err;
`ifdef SCRIPT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  rx_byte_strobe u_strobe (
    .clk          (uart_clk),
    .rst_n        (rst_n),
    .data_receive (data_receive),
    .data_valid   (data_valid),
    .stb          (stb),
    .data         (rx_byte)
  );

  assign n_clip = (int'(rx_byte) > MAX_N) ? CNT_W'(MAX_N) : CNT_W'(rx_byte);
  assign active = state_q inside {LEN, DATA_LO, DATA_HI, CHK};
  assign expired = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);

  // Next state and next registered outputs; a byte arriving on the expiry cycle beats the timeout
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    idx_d = idx_q;
    lo_d = lo_q;
    sig_d = sig_q;
    script_mode_d = script_mode_q;
    script_num_d = script_num_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    load_done_d = 1'b0;
    load_err_d = 1'b0;
    go_done = 1'b0;
    go_err = 1'b0;
`ifdef SCRIPT_CHECKSUM_EN
    csum_d = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (stb && rx_byte[1:0] == TAG_FEEDBACK)
          sig_d = {rx_byte[FB_MACHINE_BIT], rx_byte[FB_PROCESSING_BIT], rx_byte[FB_HAND_BIT], rx_byte[FB_FRONT_BIT]};
        if (stb && is_load_start(rx_byte)) begin
          state_d = LEN;
          script_mode_d = 1'b1;
        end
      end
      LEN: if (stb) begin
        n_d = n_clip;
        idx_d = '0;
        state_d = DATA_LO;
        go_done = n_clip == '0;
`ifdef SCRIPT_CHECKSUM_EN
        csum_d = rx_byte;
`endif
      end
      DATA_LO: if (stb) begin
        lo_d = rx_byte;
        state_d = DATA_HI;
`ifdef SCRIPT_CHECKSUM_EN
        csum_d = csum_q ^ rx_byte;
`endif
      end
      DATA_HI: if (stb) begin
        wr_en_d = 1'b1;
        wr_addr_d = idx_q[ADDR_W-1:0];
        wr_data_d = {rx_byte, lo_q};
        idx_d = idx_q + 1'b1;
`ifdef SCRIPT_CHECKSUM_EN
        csum_d = csum_q ^ rx_byte;
        state_d = (idx_d == n_q) ? CHK : DATA_LO;
`else
        state_d = DATA_LO;
        go_done = idx_d == n_q;
`endif
      end
`ifdef SCRIPT_CHECKSUM_EN
      CHK: if (stb) begin
        go_done = rx_byte == csum_q;
        go_err = rx_byte != csum_q;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (active && !stb && expired) go_err = 1'b1;
    tmo_d = (active && !stb && !expired) ? tmo_q + 1'b1 : '0;
    if (go_done) begin
      state_d = DONE;
      load_done_d = 1'b1;
      script_mode_d = 1'b0;
      script_num_d = 8'(n_d);
    end
    if (go_err) begin
      state_d = ERR;
      load_err_d = 1'b1;
      script_mode_d = 1'b0;
    end
  end

  // State and output registers; synchronous active-low reset clears everything
  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q <= '0;
      idx_q <= '0;
      lo_q <= '0;
      tmo_q <= '0;
      sig_q <= '0;
      script_mode_q <= 1'b0;
      script_num_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      load_done_q <= 1'b0;
      load_err_q <= 1'b0;
`ifdef SCRIPT_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      idx_q <= idx_d;
      lo_q <= lo_d;
      tmo_q <= tmo_d;
      sig_q <= sig_d;
      script_mode_q <= script_mode_d;
      script_num_q <= script_num_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      load_done_q <= load_done_d;
      load_err_q <= load_err_d;
`ifdef SCRIPT_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  assign {sig_machine, sig_processing, sig_hand, sig_front} = sig_q;
  assign script_mode = script_mode_q;
  assign script_num = script_num_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign load_done = load_done_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// tb_uart_rx_frame_decoder: randomized frames checked against a frame-level reference model
module tb_uart_rx_frame_decoder;
  localparam int ADDR_W = 3;
  localparam int TMO = 40;
  localparam int NMAX = 1 << ADDR_W;
  logic uart_clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_valid = 1'b0;
  logic [7:0] data_receive = 8'h00;
  logic sig_front, sig_hand, sig_processing, sig_machine, script_mode, wr_en, load_done, load_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0] wr_data;
  logic [7:0] script_num;
  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
  logic [7:0] exp_num = 8'h00;
  logic [3:0] exp_sig = 4'h0;
  logic [31:0] obs_wr[$], exp_wr[$];
  logic [15:0] ins_q[$];

  uart_rx_frame_decoder #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .uart_clk       (uart_clk),
    .rst_n          (rst_n),
    .data_receive   (data_receive),
    .data_valid     (data_valid),
    .sig_front      (sig_front),
    .sig_hand       (sig_hand),
    .sig_processing (sig_processing),
    .sig_machine    (sig_machine),
    .script_mode    (script_mode),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .script_num     (script_num),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  always #5 uart_clk = ~uart_clk;

  // Record every write and pulse the DUT emits
  always @(negedge uart_clk) begin
    if (wr_en) obs_wr.push_back(32'({wr_addr, wr_data}));
    if (load_done) done_cnt++;
    if (load_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sigs();
    return {sig_machine, sig_processing, sig_hand, sig_front};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_receive = b;
    data_valid = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge uart_clk);
    #1 data_valid = 1'b0;
    repeat ($urandom_range(1, 2)) @(posedge uart_clk);
    #1;
  endtask

  task automatic settle_and_check(input string tag);
    idle(4);
    check({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
    while (obs_wr.size() > 0 && exp_wr.size() > 0) check({tag, "_wr"}, obs_wr.pop_front(), exp_wr.pop_front());
    obs_wr.delete();
    exp_wr.delete();
    check({tag, "_done"}, done_cnt, exp_done);
    check({tag, "_err"}, err_cnt, exp_err);
    check({tag, "_num"}, script_num, exp_num);
    check({tag, "_mode"}, script_mode, 0);
    check({tag, "_sig"}, sigs(), exp_sig);
  endtask

  task automatic fill_random();
    ins_q.delete();
    for (int i = 0; i < NMAX; i++) ins_q.push_back(16'($urandom));
  endtask

  task automatic run_load(input logic [7:0] n, input string tag);
    int m;
    logic [7:0] cs;
    m = (int'(n) > NMAX) ? NMAX : int'(n);
    cs = n;
    send_byte(8'h06);
    check({tag, "_mode_on"}, script_mode, 1);
    send_byte(n);
    for (int i = 0; i < m; i++) begin
      send_byte(ins_q[i][7:0]);
      send_byte(ins_q[i][15:8]);
      cs ^= ins_q[i][7:0] ^ ins_q[i][15:8];
      exp_wr.push_back(32'(i << 16) | 32'(ins_q[i]));
    end
`ifdef SCRIPT_CHECKSUM_EN
    if (m > 0) send_byte(cs);
`endif
    exp_done++;
    exp_num = 8'(m);
    settle_and_check(tag);
  endtask

  initial begin
    int lat;
    logic [7:0] b;
    idle(3);
    check("rst_sig", sigs(), 0);
    check("rst_mode", script_mode, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_num", script_num, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    rst_n = 1'b1;
    idle(2);
    data_receive = 8'b0010_1101;
    data_valid = 1'b1;
    @(negedge uart_clk);
    check("fb_before_edge", sigs(), 4'h0);
    @(posedge uart_clk);
    #1 check("fb_next_cycle", sigs(), 4'b1011);
    data_receive = 8'h01;
    repeat (2) @(posedge uart_clk);
    #1 check("fb_held_valid", sigs(), 4'b1011);
    data_valid = 1'b0;
    exp_sig = 4'b1011;
    settle_and_check("fb");
    ins_q.delete();
    run_load(8'd0, "load0");
    ins_q = '{16'h1234, 16'hABCD};
    run_load(8'd2, "load2");
    send_byte(8'h06);
    send_byte(8'h03);
    data_receive = 8'h11;
    data_valid = 1'b1;
    @(posedge uart_clk);
    #1 data_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= TMO + 5; k++) begin
      @(negedge uart_clk);
      if (load_err) begin
        lat = k;
        break;
      end
    end
    check("tmo_latency", lat, TMO + 1);
    exp_err++;
    settle_and_check("tmo");
    ins_q = '{16'h3D3D};
    run_load(8'd1, "fb_in_load");
    fill_random();
    run_load(8'd12, "clip");
`ifdef SCRIPT_CHECKSUM_EN
    send_byte(8'h06);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h01 ^ 8'h55 ^ 8'h66 ^ 8'hFF);
    exp_wr.push_back(32'h0000_6655);
    exp_err++;
    settle_and_check("bad_csum");
`endif
    send_byte(8'h06);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hCD);
    rst_n = 1'b0;
    @(posedge uart_clk);
    #1;
    check("rst_mid_sig", sigs(), 0);
    check("rst_mid_mode", script_mode, 0);
    check("rst_mid_num", script_num, 0);
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_wr_data", wr_data, 0);
    rst_n = 1'b1;
    exp_sig = 4'h0;
    exp_num = 8'h00;
    exp_wr.push_back(32'h0000_1234);
    settle_and_check("rst_mid");
    send_byte(8'h05);
    exp_sig = 4'b0001;
    settle_and_check("post_rst_fb");
    for (int it = 0; it < 30; it++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          b[1:0] = 2'b01;
          send_byte(b);
          exp_sig = b[5:2];
          settle_and_check("rnd_fb");
        end
        1: begin
          if (b[1:0] == 2'b01) b[1:0] = 2'b11;
          if (b[1:0] == 2'b10) b[2] = 1'b0;
          send_byte(b);
          settle_and_check("rnd_ignored");
        end
        default: begin
          fill_random();
          run_load(8'($urandom_range(0, NMAX + 4)), "rnd_load");
        end
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
